// File: rtl/phase_pkg.sv
// phase_pkg -- shared definitions for the phase scheduler.
//
// Holds the phase codes, the phase-to-duration mapping and the width of
// the "ticks remaining" counter, so the scheduler and anything observing
// it agree on the encoding.
//
// Build option: EMERG_PREEMPT_EN (used by phase_scheduler, not here).
package phase_pkg;

  localparam int PHASE_W = 3;
  localparam int REM_W   = 4;

  typedef enum logic [PHASE_W-1:0] {
    N_GREEN  = 3'd0,
    N_YELLOW = 3'd1,
    RED_1    = 3'd2,
    E_LEFT   = 3'd3,
    E_GREEN  = 3'd4,
    E_YELLOW = 3'd5,
    RED_2    = 3'd6,
    N_LEFT   = 3'd7
  } phase_t;

  // The sequence is a fixed ring, so the successor is just code+1 mod 8.
  function automatic phase_t next_phase(input phase_t p);
    return phase_t'(p + 3'd1);
  endfunction

  // Ticks spent in a phase. N_GREEN is untimed and reports 0.
  function automatic logic [REM_W-1:0] phase_duration(
    input phase_t           p,
    input logic [REM_W-1:0] long_ticks,
    input logic [REM_W-1:0] short_ticks
  );
    case (p)
      N_GREEN:                            return '0;
      N_YELLOW, E_LEFT, E_YELLOW, N_LEFT: return long_ticks;
      default:                            return short_ticks;
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen -- prescaler producing one timing tick every TICK_CYCLES clocks.
//
// Ports:
//   clk    : clock
//   resetn : asynchronous active-low reset
//   clear  : synchronous hold; counter parked at 0, tick low
//   tick   : registered one-cycle pulse, high during the last cycle of each
//            TICK_CYCLES period, so a consumer acting on it at the next edge
//            lands exactly on the period boundary
//
// Build option: none (EMERG_PREEMPT_EN does not affect this block).
module tick_gen #(
  parameter int unsigned TICK_CYCLES = 50000000
) (
  input  logic clk,
  input  logic resetn,
  input  logic clear,
  output logic tick
);

  localparam int unsigned     CW       = $clog2(TICK_CYCLES);
  localparam logic [CW-1:0]   LAST     = CW'(TICK_CYCLES - 1);
  localparam logic [CW-1:0]   PRE_LAST = CW'(TICK_CYCLES - 2);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else if (clear) begin
      cnt_reg <= '0;
      tick    <= 1'b0;
    end else begin
      cnt_reg <= (cnt_reg == LAST) ? '0 : cnt_reg + CW'(1);
      // Registered one cycle early so the pulse coincides with cnt == LAST.
      tick    <= (cnt_reg == PRE_LAST);
    end
  end

endmodule

// File: rtl/phase_scheduler.sv
// phase_scheduler -- fixed eight-phase sequencer started by requests.
//
// Idles in N_GREEN until a request arrives, then walks 1..7 back to 0,
// each timed phase lasting its duration in ticks. Requests seen while the
// sequence runs are remembered and start another sequence on return.
//
// Ports:
//   clk       : clock
//   resetn    : asynchronous active-low reset
//   sensor    : vehicle-waiting request (level or pulse)
//   emergency : emergency request (level or pulse)
//   phase     : current phase code (registered)
//   remaining : ticks left in current phase, 0 in N_GREEN (registered)
//   tick      : one-cycle pulse at each tick boundary (registered)
//   busy      : high whenever phase != N_GREEN
//
// Build option: EMERG_PREEMPT_EN -- when defined, emergency during E_LEFT or
// E_GREEN cuts the phase short so it ends at the next tick.
module phase_scheduler
  import phase_pkg::*;
#(
  parameter int unsigned TICK_CYCLES = 50000000,
  parameter int unsigned LONG_TICKS  = 10,
  parameter int unsigned SHORT_TICKS = 5
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               sensor,
  input  logic               emergency,
  output logic [PHASE_W-1:0] phase,
  output logic [REM_W-1:0]   remaining,
  output logic               tick,
  output logic               busy
);

  localparam logic [REM_W-1:0] LONG_LD  = REM_W'(LONG_TICKS);
  localparam logic [REM_W-1:0] SHORT_LD = REM_W'(SHORT_TICKS);

  phase_t           phase_reg, phase_next;
  logic [REM_W-1:0] rem_reg, rem_next;
  logic             pend_reg, pend_next;
  logic             req_prev_reg;
  logic             req, req_rise, tick_int, idle;
  phase_t           succ;

  assign idle     = (phase_reg == N_GREEN);
  assign req      = sensor | emergency;
  // A request held high across the starting edge belongs to the sequence it
  // started; only a fresh assertion during the run is remembered.
  assign req_rise = req & ~req_prev_reg;
  assign succ     = next_phase(phase_reg);

  // Prescaler held at 0 while idle; on the start edge it is still held, so
  // the first tick period begins exactly at phase entry.
  tick_gen #(
    .TICK_CYCLES(TICK_CYCLES)
  ) u_tick_gen (
    .clk   (clk),
    .resetn(resetn),
    .clear (idle),
    .tick  (tick_int)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase_reg    <= N_GREEN;
      rem_reg      <= '0;
      pend_reg     <= 1'b0;
      req_prev_reg <= 1'b0;
    end else begin
      phase_reg    <= phase_next;
      rem_reg      <= rem_next;
      pend_reg     <= pend_next;
      req_prev_reg <= req;
    end
  end

  always_comb begin
    phase_next = phase_reg;
    rem_next   = rem_reg;
    pend_next  = pend_reg;

    if (idle) begin
      // sensor and emergency share one start, so simultaneous requests
      // launch a single sequence.
      if (req || pend_reg) begin
        phase_next = N_YELLOW;
        rem_next   = LONG_LD;
        pend_next  = 1'b0;
      end
    end else begin
      // Also covers the 7->0 edge: phase_reg is still N_LEFT there.
      if (req_rise) begin
        pend_next = 1'b1;
      end

      if (tick_int) begin
        if (rem_reg > 4'd1) begin
          rem_next = rem_reg - 4'd1;
        end else begin
          phase_next = succ;
          rem_next   = phase_duration(succ, LONG_LD, SHORT_LD);
        end
      end

`ifdef EMERG_PREEMPT_EN
      // Leave the prescaler running: the phase ends at the next natural tick.
      if (emergency && (phase_reg == E_LEFT || phase_reg == E_GREEN)
          && (rem_reg > 4'd1)) begin
        rem_next = 4'd1;
      end
`else
      // emergency is treated purely as a request; timing is untouched.
`endif
    end
  end

  assign phase     = phase_reg;
  assign remaining = rem_reg;
  assign tick      = tick_int;
  assign busy      = ~idle;

endmodule

// File: tb/tb_phase_scheduler.sv
// tb_phase_scheduler -- directed bench for phase_scheduler.
//
// Expected phase entries (code, entry cycle, remaining on entry) are queued
// when stimulus is applied; a monitor pops one per observed phase change.
// Build option EMERG_PREEMPT_EN selects the matching preemption expectation.
module tb_phase_scheduler;

  localparam int TC    = 4;
  localparam int LONG  = 3;
  localparam int SHORT = 2;

  typedef struct {
    int ph;
    int cyc;
    int rem;
  } exp_t;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       sensor = 1'b0;
  logic       emergency = 1'b0;
  logic [2:0] phase;
  logic [3:0] remaining;
  logic       tick;
  logic       busy;

  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   tick_cnt = 0;
  bit   mon_en = 1'b0;
  logic [2:0] last_phase = 3'd0;
  exp_t sb[$];
  exp_t mon_e;

  phase_scheduler #(
    .TICK_CYCLES(TC),
    .LONG_TICKS (LONG),
    .SHORT_TICKS(SHORT)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .sensor   (sensor),
    .emergency(emergency),
    .phase    (phase),
    .remaining(remaining),
    .tick     (tick),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Queue phase entries 1,2,..,7,0 starting at cycle s; sh cycles are
  // removed from phase 4 (preemption). Only the first n entries are queued.
  task automatic push_seq(input int s, input int sh, input int n, output int end_cyc);
    int t;
    t = s;
    for (int p = 1; p <= 8 && p <= n; p++) begin
      exp_t e;
      int   ph;
      ph    = p % 8;
      e.ph  = ph;
      e.cyc = t;
      e.rem = (ph == 0) ? 0 : ((ph % 2 == 1) ? LONG : SHORT);
      sb.push_back(e);
      if (ph != 0) t += ((ph % 2 == 1) ? LONG : SHORT) * TC - ((ph == 4) ? sh : 0);
    end
    end_cyc = t;
  endtask

  // One-cycle sensor pulse; returns the edge at which it is sampled.
  task automatic pulse_sensor(output int s);
    s = cyc + 1;
    sensor = 1'b1;
    next_edge();
    sensor = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    chk(tag, sb.size(), 0);
    sb.delete();
    next_edge();
  endtask

  initial begin
    int s, e_end, tc0, sh, dummy;

    // Monitor: one queued entry per phase change, sampled on the falling edge.
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (tick === 1'b1) tick_cnt++;
          if (phase !== last_phase) begin
            total++;
            assert (sb.size() != 0) else begin
              bad++;
              $error("FAIL unexpected_change: observed phase=%0d expected no change from %0d at cycle %0d",
                     phase, last_phase, cyc);
            end
            if (sb.size() != 0) begin
              mon_e = sb.pop_front();
              chk("entry_phase", 32'(phase), mon_e.ph);
              chk("entry_cycle", cyc, mon_e.cyc);
              chk("entry_rem", 32'(remaining), mon_e.rem);
              chk("entry_busy", 32'(busy), 32'(mon_e.ph != 0));
            end
          end
        end
        last_phase = phase;
      end
    join_none

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_phase", 32'(phase), 0);
    chk("reset_rem", 32'(remaining), 0);
    chk("reset_tick", 32'(tick), 0);
    chk("reset_busy", 32'(busy), 0);
    resetn = 1'b1;
    mon_en = 1'b1;

    // 100 idle cycles: nothing moves, no ticks.
    tc0 = tick_cnt;
    repeat (100) next_edge();
    chk("idle_phase", 32'(phase), 0);
    chk("idle_rem", 32'(remaining), 0);
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ticks", tick_cnt - tc0, 0);
    $display("idle: 100 cycles, phase=%0d ticks=%0d", phase, tick_cnt - tc0);

    // Full sequence from a single sensor pulse.
    tc0 = tick_cnt;
    pulse_sensor(s);
    push_seq(s, 0, 8, e_end);
    chk("start_rem", 32'(remaining), LONG);
    chk("start_busy", 32'(busy), 1);
    repeat (3) next_edge();
    chk("first_tick", 32'(tick), 1);
    chk("rem_before_tick", 32'(remaining), LONG);
    next_edge();
    chk("tick_low", 32'(tick), 0);
    chk("rem_after_tick", 32'(remaining), LONG - 1);
    drain("seq_drain", 200);
    chk("seq_ticks", tick_cnt - tc0, 4 * LONG + 3 * SHORT);
    $display("sequence: start=%0d end=%0d ticks=%0d", s, e_end, tick_cnt - tc0);

    // Request during phase 3: one idle cycle, then a second sequence.
    pulse_sensor(s);
    push_seq(s, 0, 8, e_end);
    push_seq(e_end + 1, 0, 8, dummy);
    repeat (25) next_edge();
    chk("mid_phase3", 32'(phase), 3);
    pulse_sensor(dummy);
    drain("pending_drain", 300);
    $display("pending: first end=%0d, restart=%0d", e_end, e_end + 1);

    // Emergency in phase 4 with remaining=2.
`ifdef EMERG_PREEMPT_EN
    sh = 4;
`else
    sh = 0;
`endif
    pulse_sensor(s);
    push_seq(s, sh, 8, e_end);
    push_seq(e_end + 1, 0, 8, dummy);
    repeat (33) next_edge();
    chk("pre_emerg_rem", 32'(remaining), 2);
    emergency = 1'b1;
    next_edge();
    emergency = 1'b0;
    chk("emerg_phase", 32'(phase), 4);
`ifdef EMERG_PREEMPT_EN
    chk("emerg_rem", 32'(remaining), 1);
`else
    chk("emerg_rem", 32'(remaining), 2);
`endif
    drain("emerg_drain", 300);
    $display("emergency: phase4 shortened by %0d cycles", sh);

    // Reset mid phase 5, with a request pending that must be discarded.
    pulse_sensor(s);
    push_seq(s, 0, 5, dummy);
    repeat (25) next_edge();
    pulse_sensor(dummy);
    repeat (19) next_edge();
    chk("pre_reset_phase", 32'(phase), 5);
    sb.push_back('{ph: 0, cyc: cyc, rem: 0});
    resetn = 1'b0;
    #1;
    chk("async_phase", 32'(phase), 0);
    chk("async_rem", 32'(remaining), 0);
    chk("async_tick", 32'(tick), 0);
    chk("async_busy", 32'(busy), 0);
    next_edge();
    resetn = 1'b1;
    repeat (20) next_edge();
    chk("post_reset_phase", 32'(phase), 0);
    chk("post_reset_rem", 32'(remaining), 0);
    chk("post_reset_queue", sb.size(), 0);
    $display("reset: mid phase 5, idle afterwards phase=%0d", phase);

    // sensor and emergency together for 3 cycles: exactly one sequence.
    s = cyc + 1;
    sensor = 1'b1;
    emergency = 1'b1;
    push_seq(s, 0, 8, e_end);
    repeat (3) next_edge();
    sensor = 1'b0;
    emergency = 1'b0;
    drain("dual_drain", 200);
    repeat (10) next_edge();
    chk("dual_idle_phase", 32'(phase), 0);
    chk("dual_queue", sb.size(), 0);
    $display("dual request: single sequence ending at %0d", e_end);

    // Request in the same cycle as the 7->0 transition.
    pulse_sensor(s);
    push_seq(s, 0, 8, e_end);
    push_seq(e_end + 1, 0, 8, dummy);
    repeat (71) next_edge();
    chk("pre_wrap_phase", 32'(phase), 7);
    pulse_sensor(dummy);
    drain("wrap_drain", 300);
    $display("wrap request: restart at %0d", e_end + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/phase_scheduler.md
PHASE_SCHEDULER -- requirements
Module: phase_scheduler

Interface
REQ-001 Parameter TICK_CYCLES, default 50000000: clk cycles per timing tick; legal range >=2.
REQ-002 Parameter LONG_TICKS, default 10: ticks in a long phase; legal range 1..15.
REQ-003 Parameter SHORT_TICKS, default 5: ticks in a short phase; legal range 1..15.
REQ-004 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-005 Port resetn, input, 1: reset, asynchronous, active-low.
REQ-006 Port sensor, input, 1: vehicle-waiting request, level or single-cycle pulse.
REQ-007 Port emergency, input, 1: emergency request, level or single-cycle pulse.
REQ-008 Port phase, output, 3: current phase code, registered.
REQ-009 Port remaining, output, 4: ticks left in the current phase, registered; 0 in N_GREEN.
REQ-010 Port tick, output, 1: one-cycle pulse at each tick boundary, registered.
REQ-011 Port busy, output, 1: high whenever phase != N_GREEN.

Function
REQ-012 Phase codes and durations: N_GREEN=0 (untimed), N_YELLOW=1 (long), RED_1=2 (short), E_LEFT=3 (long), E_GREEN=4 (short), E_YELLOW=5 (long), RED_2=6 (short), N_LEFT=7 (long).
REQ-013 The sequence SHALL be fixed: 0->1->2->3->4->5->6->7->0.
REQ-014 go = sensor | emergency | req_pending, evaluated every cycle in N_GREEN.
REQ-015 On the first edge with go=1 in N_GREEN:
- phase becomes 1 on that edge.
- remaining is loaded with LONG_TICKS.
- the prescaler is cleared.
- req_pending is cleared.
REQ-016 The prescaler SHALL count 0..TICK_CYCLES-1 and wrap. tick SHALL pulse for one cycle when it wraps. It SHALL run only while busy, and SHALL be held at 0 in N_GREEN.
REQ-017 On each tick with remaining>1, remaining SHALL decrement by 1.
REQ-018 On a tick with remaining==1, phase SHALL advance and remaining SHALL reload with the next phase's duration (0 when entering N_GREEN).
REQ-019 Each timed phase SHALL therefore last exactly duration*TICK_CYCLES clk cycles.
REQ-020 A sensor or emergency sample of 1 while busy SHALL set sticky req_pending.
REQ-021 If req_pending is set on return to N_GREEN, phase SHALL stay 0 for exactly one cycle and then become 1.
REQ-022 Simultaneous sensor and emergency SHALL start one sequence only.
REQ-023 A request arriving in the same cycle as the 7->0 transition SHALL set req_pending.

Reset
REQ-024 While resetn=0, outputs SHALL be forced immediately, without waiting for clk: phase=0, remaining=0, tick=0, busy=0, req_pending=0, prescaler=0.
REQ-025 Reset mid-phase SHALL abandon the sequence and discard pending requests. After release, the block SHALL operate normally from the first rising clk.

Configuration
REQ-026 Macro EMERG_PREEMPT_EN.
- Defined: emergency=1 while phase is 3 or 4 with remaining>1 SHALL set remaining to 1 on that edge. The prescaler is not disturbed, so the phase ends at the next tick.
- Undefined: emergency SHALL behave exactly like sensor (REQ-014, REQ-020) and SHALL never alter remaining.

Structure
REQ-027 Phase-code constants, phase-duration selection (long/short per code), and the 4-bit remaining width SHALL live in shared package phase_pkg.
REQ-028 The prescaler SHALL be a sub-module tick_gen with ports clk, resetn, clear, tick. Phase sequencing and the duration counter SHALL stay in phase_scheduler.

Verification
Bench parameters: TICK_CYCLES=4, LONG_TICKS=3, SHORT_TICKS=2.
REQ-029 Reset, then 100 idle cycles -> phase=0, remaining=0, busy=0, tick never pulses.
REQ-030 One-cycle sensor pulse at cycle 10 -> phase=1 from cycle 11 for 12 cycles, then phase 2 for 8 cycles, and so on through the sequence -> phase=0 again after 72 cycles.
REQ-031 One-cycle sensor pulse during phase 3 -> after return to 0, phase holds 0 for exactly 1 cycle, then becomes 1.
REQ-032 EMERG_PREEMPT_EN defined: emergency pulse in phase 4 at remaining=2 -> remaining=1, phase=5 at the next tick pulse. Macro undefined: same stimulus -> phase 4 runs its full 8 cycles.
REQ-033 resetn low for 1 cycle mid phase 5 -> outputs zero immediately without a clk edge; after release phase=0 until the next request.
REQ-034 sensor and emergency high together for 3 cycles in N_GREEN -> exactly one sequence, and req_pending clear at its end.
